// File: rtl/rst_seq_if.sv
// rtl/rst_seq_if.sv - Control/status interface of the reset sequencer
//
// Purpose: groups the lock input, software controls and the reset/status
// outputs of rst_seq so a single port carries them.
// Signals:
//   clk_locked  lock status from the clock generator (asynchronous)
//   soft_rst    software reset request
//   lost_clr    clears lock_lost and loss_cnt
//   rst_o       NCH active-high domain resets
//   rst_done    all rst_o low
//   lock_lost   sticky lock-loss flag
//   loss_cnt    saturating lock-loss count
// Modports: master drives the controls, slave is the sequencer.
interface rst_seq_if #(
  parameter int NCH = 4
);
  logic           clk_locked;
  logic           soft_rst;
  logic           lost_clr;
  logic [NCH-1:0] rst_o;
  logic           rst_done;
  logic           lock_lost;
  logic [7:0]     loss_cnt;

  modport master (
    output clk_locked, soft_rst, lost_clr,
    input  rst_o, rst_done, lock_lost, loss_cnt
  );

  modport slave (
    input  clk_locked, soft_rst, lost_clr,
    output rst_o, rst_done, lock_lost, loss_cnt
  );
endinterface

// File: rtl/rst_seq.sv
// rtl/rst_seq.sv - Lock-qualified staggered reset sequencer
//
// Purpose: holds NCH reset domains asserted until the clock generator lock
// has been stable for HOLD_CYC cycles, then releases them in index order
// every STAGGER cycles. A filtered lock loss (FILT unlocked cycles) restarts
// the whole sequence; a software request in RUN re-asserts all resets for
// SOFT_CYC cycles and releases them again without a lock re-hold.
// Ports:
//   PCI_CLK   sole clock
//   PCI_RSTn  asynchronous active-low reset
//   bus       rst_seq_if.slave (clk_locked, soft_rst, lost_clr in;
//             rst_o, rst_done, lock_lost, loss_cnt out)
module rst_seq #(
  parameter int NCH      = 4,
  parameter int HOLD_CYC = 16,
  parameter int STAGGER  = 8,
  parameter int FILT     = 4,
  parameter int SOFT_CYC = 32,
  parameter int CNT_W    = 16
) (
  input  logic     PCI_CLK,
  input  logic     PCI_RSTn,
  rst_seq_if.slave bus
);

  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER - 1);
  localparam logic [CNT_W-1:0] SOFT_LAST = CNT_W'(SOFT_CYC - 1);
  localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(FILT - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NCH - 1);
  localparam logic [NCH-1:0]   ALL_ON    = {NCH{1'b1}};
  // All resets asserted except index 0: the value on entry to RELEASE.
  localparam logic [NCH-1:0]   FIRST_REL = ALL_ON << 1;

  typedef enum logic [2:0] {
    S_WAIT_LOCK,
    S_HOLD,
    S_RELEASE,
    S_RUN,
    S_SOFT
  } state_t;

  state_t           r_state, w_state_nxt;
  logic             r_sync1, r_lock_s;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_filt, w_filt_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic [NCH-1:0]   r_rst, w_rst_nxt;
  logic             r_lock_lost;
  logic [7:0]       r_loss_cnt;
  logic             w_loss;
  logic             w_enter_rel;

  // Loss is declared on the edge where the FILT-th consecutive unlocked
  // cycle is seen; the filter is idle while waiting for lock.
  assign w_loss     = (r_state != S_WAIT_LOCK) && !r_lock_s && (r_filt == FILT_LAST);
  assign w_filt_nxt = ((r_state == S_WAIT_LOCK) || r_lock_s || w_loss) ? '0 : r_filt + CNT_ONE;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_rst_nxt   = r_rst;
    w_enter_rel = 1'b0;
    if (w_loss) begin
      w_state_nxt = S_WAIT_LOCK;
      w_cnt_nxt   = '0;
      w_idx_nxt   = '0;
      w_rst_nxt   = ALL_ON;
    end else begin
      unique case (r_state)
        S_WAIT_LOCK: begin
          w_rst_nxt = ALL_ON;
          w_cnt_nxt = '0;
          if (r_lock_s) w_state_nxt = S_HOLD;
        end
        S_HOLD: begin
          if (!r_lock_s)                w_cnt_nxt   = '0;
          else if (r_cnt == HOLD_LAST)  w_enter_rel = 1'b1;
          else                          w_cnt_nxt   = r_cnt + CNT_ONE;
        end
        S_RELEASE: begin
          if (r_cnt == STAG_LAST) begin
            w_cnt_nxt = '0;
            for (int i = 0; i < NCH; i++) begin
              if (IDX_W'(i) == r_idx) w_rst_nxt[i] = 1'b0;
            end
            if (r_idx == IDX_LAST) w_state_nxt = S_RUN;
            else                   w_idx_nxt   = r_idx + IDX_ONE;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
        S_RUN: begin
          w_rst_nxt = '0;
          if (bus.soft_rst) begin
            w_state_nxt = S_SOFT;
            w_rst_nxt   = ALL_ON;
            w_cnt_nxt   = '0;
          end
        end
        S_SOFT: begin
          if (r_cnt == SOFT_LAST) w_enter_rel = 1'b1;
          else                    w_cnt_nxt   = r_cnt + CNT_ONE;
        end
        default: begin
          w_state_nxt = S_WAIT_LOCK;
          w_rst_nxt   = ALL_ON;
          w_cnt_nxt   = '0;
        end
      endcase
      // Shared entry into RELEASE: bit 0 drops on this edge, idx points at
      // the next bit. A single-channel build is finished immediately.
      if (w_enter_rel) begin
        w_rst_nxt   = FIRST_REL;
        w_cnt_nxt   = '0;
        w_idx_nxt   = IDX_ONE;
        w_state_nxt = (NCH == 1) ? S_RUN : S_RELEASE;
      end
    end
  end

  always_ff @(posedge PCI_CLK or negedge PCI_RSTn) begin
    if (!PCI_RSTn) begin
      r_sync1     <= 1'b0;
      r_lock_s    <= 1'b0;
      r_state     <= S_WAIT_LOCK;
      r_cnt       <= '0;
      r_filt      <= '0;
      r_idx       <= '0;
      r_rst       <= ALL_ON;
      r_lock_lost <= 1'b0;
      r_loss_cnt  <= '0;
    end else begin
      r_sync1  <= bus.clk_locked;
      r_lock_s <= r_sync1;
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_filt   <= w_filt_nxt;
      r_idx    <= w_idx_nxt;
      r_rst    <= w_rst_nxt;
      // A loss event outranks a simultaneous clear.
      if (w_loss) begin
        r_lock_lost <= 1'b1;
        if (r_loss_cnt != 8'hFF) r_loss_cnt <= r_loss_cnt + 8'd1;
      end else if (bus.lost_clr) begin
        r_lock_lost <= 1'b0;
        r_loss_cnt  <= '0;
      end
    end
  end

  assign bus.rst_o     = r_rst;
  assign bus.rst_done  = ~|r_rst;
  assign bus.lock_lost = r_lock_lost;
  assign bus.loss_cnt  = r_loss_cnt;

endmodule

// File: tb/tb_rst_seq.sv
// tb/tb_rst_seq.sv - Scoreboard bench for rst_seq
module tb_rst_seq;

  typedef struct {
    int          cyc;
    logic [13:0] v;
  } ev_t;

  logic clk    = 1'b0;
  logic rst_n  = 1'b1;
  logic rst2_n = 1'b1;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  ev_t         q1[$];
  ev_t         q2[$];
  logic [13:0] last1 = 14'h3FFF;
  logic [13:0] last2 = 14'h3FFF;
  int          m_lost = 0;
  int          m_cnt  = 0;

  rst_seq_if #(.NCH(4)) bus ();
  rst_seq_if #(.NCH(1)) bus2 ();

  rst_seq #(.NCH(4)) dut (
    .PCI_CLK (clk),
    .PCI_RSTn(rst_n),
    .bus     (bus)
  );

  rst_seq #(.NCH(1), .STAGGER(1)) dut2 (
    .PCI_CLK (clk),
    .PCI_RSTn(rst2_n),
    .bus     (bus2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected output change of the 4-channel DUT at edge 'at'.
  task automatic exp1(input int at, input logic [3:0] r, input logic d);
    logic [13:0] v;
    v = {r, d, (m_lost != 0), 8'(m_cnt)};
    if (v != last1) begin
      q1.push_back('{at, v});
      last1 = v;
    end
  endtask

  task automatic exp2(input int at, input logic r, input logic d);
    logic [13:0] v;
    v = {3'b000, r, d, 1'b0, 8'h00};
    if (v != last2) begin
      q2.push_back('{at, v});
      last2 = v;
    end
  endtask

  task automatic goto(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Full sequence after lock is first sampled at edge l.
  task automatic seq_from(input int l);
    exp1(l + 18, 4'hE, 1'b0);
    exp1(l + 26, 4'hC, 1'b0);
    exp1(l + 34, 4'h8, 1'b0);
    exp1(l + 42, 4'h0, 1'b1);
  endtask

  // Four-cycle lock drop: loss 6 edges later; returns first relocked edge.
  task automatic loss_and_relock(output int l);
    int c;
    c = cyc;
    bus.clk_locked = 1'b0;
    m_lost = 1;
    if (m_cnt < 255) m_cnt = m_cnt + 1;
    exp1(c + 6, 4'hF, 1'b0);
    goto(c + 4);
    bus.clk_locked = 1'b1;
    l = c + 5;
  endtask

  logic [13:0] seen1, seen2;
  bit          have1 = 1'b0, have2 = 1'b0;

  always @(negedge clk) begin
    logic [13:0] cur;
    ev_t         e;
    cur = {bus.rst_o, bus.rst_done, bus.lock_lost, bus.loss_cnt};
    if (!have1 || cur !== seen1) begin
      have1  = 1'b1;
      seen1  = cur;
      checks = checks + 1;
      if (q1.size() == 0) begin
        errors = errors + 1;
        $display("FAIL dut4_event: got %h at cycle %0d, expected no change", cur, cyc);
      end else begin
        e = q1.pop_front();
        if (e.cyc != cyc || e.v !== cur) begin
          errors = errors + 1;
          $display("FAIL dut4_event: got %h at cycle %0d, expected %h at cycle %0d",
                   cur, cyc, e.v, e.cyc);
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [13:0] cur;
    ev_t         e;
    cur = {3'b000, bus2.rst_o, bus2.rst_done, bus2.lock_lost, bus2.loss_cnt};
    if (!have2 || cur !== seen2) begin
      have2  = 1'b1;
      seen2  = cur;
      checks = checks + 1;
      if (q2.size() == 0) begin
        errors = errors + 1;
        $display("FAIL dut1_event: got %h at cycle %0d, expected no change", cur, cyc);
      end else begin
        e = q2.pop_front();
        if (e.cyc != cyc || e.v !== cur) begin
          errors = errors + 1;
          $display("FAIL dut1_event: got %h at cycle %0d, expected %h at cycle %0d",
                   cur, cyc, e.v, e.cyc);
        end
      end
    end
  end

  initial begin
    int c;
    int l;
    int s;
    bus.clk_locked  = 1'b0;
    bus.soft_rst    = 1'b0;
    bus.lost_clr    = 1'b0;
    bus2.clk_locked = 1'b0;
    bus2.soft_rst   = 1'b0;
    bus2.lost_clr   = 1'b0;

    // Reset values.
    #1;
    rst_n  = 1'b0;
    rst2_n = 1'b0;
    exp1(1, 4'hF, 1'b0);
    exp2(1, 1'b1, 1'b0);
    goto(2);
    rst_n  = 1'b1;
    rst2_n = 1'b1;

    // First lock: releases at L+18/26/34/42; soft_rst during RELEASE ignored.
    goto(4);
    c = cyc;
    bus.clk_locked  = 1'b1;
    bus2.clk_locked = 1'b1;
    l = c + 1;
    seq_from(l);
    exp2(l + 18, 1'b0, 1'b1);
    goto(l + 20);
    bus.soft_rst = 1'b1;
    goto(l + 21);
    bus.soft_rst = 1'b0;
    goto(l + 50);

    // Three-cycle glitch in RUN: filtered out.
    c = cyc;
    bus.clk_locked = 1'b0;
    goto(c + 3);
    bus.clk_locked = 1'b1;
    goto(c + 12);

    // Four-cycle glitch: loss, then a fresh sequence.
    loss_and_relock(l);
    seq_from(l);
    goto(l + 45);

    // One-cycle drop mid-HOLD restarts the hold count.
    loss_and_relock(l);
    seq_from(l + 8);
    goto(l + 7);
    bus.clk_locked = 1'b0;
    goto(l + 8);
    bus.clk_locked = 1'b1;
    goto(l + 60);

    // Software reset in RUN.
    c = cyc;
    bus.soft_rst = 1'b1;
    s = c + 1;
    exp1(s,      4'hF, 1'b0);
    exp1(s + 32, 4'hE, 1'b0);
    exp1(s + 40, 4'hC, 1'b0);
    exp1(s + 48, 4'h8, 1'b0);
    exp1(s + 56, 4'h0, 1'b1);
    goto(s);
    bus.soft_rst = 1'b0;
    goto(s + 60);

    // Saturating loss count; last event coincides with lost_clr.
    for (int k = 0; k < 258; k++) begin
      c = cyc;
      bus.clk_locked = 1'b0;
      m_lost = 1;
      if (m_cnt < 255) m_cnt = m_cnt + 1;
      exp1(c + 6, 4'hF, 1'b0);
      goto(c + 4);
      bus.clk_locked = 1'b1;
      if (k == 257) begin
        goto(c + 5);
        bus.lost_clr = 1'b1;
        goto(c + 6);
        bus.lost_clr = 1'b0;
      end
      goto(c + 10);
    end
    seq_from(c + 5);
    goto(c + 50);

    // lost_clr alone clears both.
    c = cyc;
    bus.lost_clr = 1'b1;
    m_lost = 0;
    m_cnt  = 0;
    exp1(c + 1, 4'h0, 1'b1);
    goto(c + 1);
    bus.lost_clr = 1'b0;
    goto(c + 3);

    // Asynchronous reset mid-RELEASE, between clock edges.
    c = cyc;
    bus.soft_rst = 1'b1;
    s = c + 1;
    exp1(s,      4'hF, 1'b0);
    exp1(s + 32, 4'hE, 1'b0);
    goto(s);
    bus.soft_rst = 1'b0;
    goto(s + 36);
    @(posedge clk);
    #2;
    exp1(s + 37, 4'hF, 1'b0);
    rst_n = 1'b0;
    goto(s + 39);
    rst_n = 1'b1;
    seq_from(s + 40);
    goto(s + 90);

    checks = checks + 1;
    if (q1.size() != 0) begin
      errors = errors + 1;
      $display("FAIL dut4_pending: %0d events outstanding, expected 0", q1.size());
    end
    checks = checks + 1;
    if (q2.size() != 0) begin
      errors = errors + 1;
      $display("FAIL dut1_pending: %0d events outstanding, expected 0", q2.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rst_seq.md
# rst_seq

Parametrised reset sequencer for the Wishbone side of the DMA core. It runs on PCI_CLK and watches the clock-generator lock signal. It holds all downstream reset domains asserted until lock has been stable for a programmable time, then releases NCH active-high resets one at a time with a programmable stagger. Beyond a plain post-lock shift-register release, it adds:
- filtered lock-loss detection with automatic re-sequencing;
- a software-requested reset;
- sticky status and a saturating count of lock-loss events.

## Interface
Parameters:
- NCH, 4: number of reset outputs (≥1); released in index order, 0 first.
- HOLD_CYC, 16: cycles of stable lock before the first release (≥1).
- STAGGER, 8: cycles between consecutive releases (≥1).
- FILT, 4: consecutive unlocked cycles that count as a lock loss (≥1).
- SOFT_CYC, 32: assertion length of a software reset (≥1).
- CNT_W, 16: internal counter width; must hold max(HOLD_CYC, STAGGER, SOFT_CYC, FILT).

Ports:
- PCI_CLK  in  1  sole clock.
- PCI_RSTn  in  1  asynchronous, active-low reset.
- clk_locked  in  1  lock status from the clock generator; asynchronous, synchronised internally.
- soft_rst  in  1  synchronous software reset request; honoured only in RUN.
- lost_clr  in  1  synchronous; clears lock_lost and loss_cnt.
- rst_o  out  NCH  active-high domain resets, registered.
- rst_done  out  1  high when all rst_o are low.
- lock_lost  out  1  sticky lock-loss flag.
- loss_cnt  out  8  lock-loss count, saturating at 255.

## Operation
- Synchronisation: clk_locked passes through two flops to form lock_s. All decisions use lock_s only.
- States: WAIT_LOCK, HOLD, RELEASE, RUN, SOFT. Reset state is WAIT_LOCK.
- WAIT_LOCK: all rst_o=1. When lock_s=1, go to HOLD with the counter cleared.
- HOLD: the counter increments every cycle while lock_s=1. Any cycle with lock_s=0 clears it. At count HOLD_CYC−1, go to RELEASE with idx=0.
- RELEASE:
  - rst_o[0] drops on entry.
  - Each further STAGGER cycles, the next index drops.
  - Released bits stay low.
  - When rst_o[NCH−1] drops, go to RUN.
- RUN: all rst_o=0. If soft_rst=1, go to SOFT.
- SOFT:
  - All rst_o=1 and rst_done=0 from the entry edge.
  - After SOFT_CYC cycles, go to RELEASE with idx=0; rst_o[0] drops on that edge.
  - No lock re-hold is performed.
- Lock-loss filter:
  - A counter of consecutive lock_s=0 cycles, active in HOLD, RELEASE, RUN and SOFT.
  - Reaching FILT is a loss event. On the next edge: state goes to WAIT_LOCK, all rst_o=1, rst_done=0, lock_lost=1, loss_cnt increments (saturating).
  - Any lock_s=1 cycle clears the filter counter.
  - In HOLD, the hold counter clears on any unlocked cycle, independently of the filter.
- Priority: loss event > soft_rst.
  - soft_rst is ignored outside RUN.
  - A soft_rst held high re-enters SOFT on each RUN entry.
- Status: if lost_clr and a loss event occur in the same cycle, the set/increment wins. loss_cnt stays at 255 once it is reached.
- rst_o bits change only as described above. No bit is ever released out of order.

## Timing
- Reset values: rst_o all 1, rst_done 0, lock_lost 0, loss_cnt 0, state WAIT_LOCK, all counters 0.
- Asynchronous reset forces these values immediately, mid-sequence included. The synchroniser flops also reset to 0.
- Lock latency (L = first edge where clk_locked=1 is sampled):
  - lock_s=1 after edge L+1.
  - HOLD is entered at edge E0 = L+2.
- rst_o[i] falls at edge E0 + HOLD_CYC + i·STAGGER.
- rst_done rises on the same edge as rst_o[NCH−1] falls. With NCH=1, that is E0 + HOLD_CYC.
- Lock loss: if clk_locked drops before edge D, lock_s=0 from D+1. All rst_o rise at D+1+FILT.
- Soft reset: soft_rst sampled at edge S gives rst_o all 1 from S. rst_o[0] falls at S + SOFT_CYC.

## Test plan
- Default parameters, clk_locked rises at L → rst_o[0..3] fall at L+18, L+26, L+34, L+42; rst_done rises at L+42.
- Lock glitch low for 3 cycles during RUN (FILT=4) → no change. Glitch of 4 cycles → all rst_o=1, lock_lost=1, loss_cnt=1; a fresh full sequence follows on relock.
- Lock drops for 1 cycle mid-HOLD → the hold restarts and the first release is delayed by exactly the elapsed hold plus the glitch.
- soft_rst pulse in RUN at S → rst_o=4'hF from S; rst_o[0] falls at S+32; soft_rst pulse during RELEASE is ignored.
- 260 loss events → loss_cnt=255. lost_clr coincident with a loss event → lock_lost=1, count held at 255. lost_clr alone → both cleared.
- PCI_RSTn asserted mid-RELEASE → all outputs at reset values immediately. NCH=1, STAGGER=1 build → rst_done coincides with rst_o[0] release.
